// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small byte FIFO on a ready/valid output stream.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_bits,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state, state_next;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             push_c, ferr_c;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [OCC_W-1:0] count, count_next;
    logic             pop_c, full_c, accept_c, ovf_c;
    logic [7:0]       head_next;

    // Two-flop synchroniser for the asynchronous serial pin
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bit timing and sampling decisions
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        push_c       = 1'b0;
        ferr_c       = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        push_c     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ferr_c     = 1'b1;
                        state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Bit counter, bit index and shift register
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // FIFO control: accept/drop decision, pointer and occupancy update, next head byte
    always_comb begin
        pop_c       = out_valid && out_ready;
        full_c      = (count == OCC_FULL);
        accept_c    = push_c && (!full_c || pop_c);
        ovf_c       = push_c && full_c && !pop_c;
        rd_ptr_next = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_next = accept_c ? wr_ptr + PTR_W'(1) : wr_ptr;
        count_next  = count;
        unique case ({accept_c, pop_c})
            2'b10:   count_next = count + OCC_W'(1);
            2'b01:   count_next = count - OCC_W'(1);
            default: count_next = count;
        endcase
        // A byte written this cycle into the new head slot bypasses the array
        if (count_next == '0) begin
            head_next = '0;
        end else if (accept_c && (wr_ptr == rd_ptr_next)) begin
            head_next = shift;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // FIFO storage array
    always_ff @(posedge clock) begin
        if (accept_c) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers, occupancy and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_bits  <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_bits  <= head_next;
            frame_err <= ferr_c;
            overflow  <= ovf_c;
            busy      <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios followed by random frames.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    // Negedge index (cycles after the start-bit edge) just before the stop sample edge:
    // 2 sync stages, 1 idle detect, half bit, 8 data bits, 1 stop bit, minus one.
    localparam int          STOP_OFS = 2 + CPB / 2 + 9 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_bits;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] model_q[$];
    int         cyc = 0;
    logic       rst_q = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;
    bit         exp_ferr = 1'b0;
    bit         exp_ovf = 1'b0;
    bit         rnd_ready = 1'b0;
    int         mon_sz;
    bit         mon_pop;
    ev_t        mon_ev;
    logic [7:0] mon_b;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits (out_bits),
        .frame_err(frame_err),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT outputs with the reference queue, then advance the model
    always @(negedge clock) begin
        if (cyc > 0) begin
            if (!rst_q) begin
                check("rst_valid", 32'(out_valid), 0);
                check("rst_bits", 32'(out_bits), 0);
                check("rst_ferr", 32'(frame_err), 0);
                check("rst_ovf", 32'(overflow), 0);
                check("rst_busy", 32'(busy), 0);
                model_q.delete();
            end else begin
                check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
                if (model_q.size() != 0) begin
                    check("out_bits", 32'(out_bits), 32'(model_q[0]));
                end
                check("frame_err", 32'(frame_err), 32'(exp_ferr));
                check("overflow", 32'(overflow), 32'(exp_ovf));
            end
            exp_ferr = 1'b0;
            exp_ovf  = 1'b0;
            if (reset) begin
                mon_sz  = model_q.size();
                mon_pop = (mon_sz != 0) && out_ready;
                if (mon_pop) begin
                    mon_b = model_q.pop_front();
                end
                if (ev_q.size() != 0 && ev_q[0].at == cyc) begin
                    mon_ev = ev_q.pop_front();
                    if (!mon_ev.ok) begin
                        exp_ferr = 1'b1;
                    end else if (mon_sz == DEPTH && !mon_pop) begin
                        exp_ovf = 1'b1;
                    end else begin
                        model_q.push_back(mon_ev.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_ready) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drive one frame; abort_bit >= 0 pulses reset midway through that data bit
    task automatic send_frame(input logic [7:0] b, input bit stop_ok = 1'b1,
                              input int extra_low = 0, input bit ready_pulse = 1'b0,
                              input int abort_bit = -1);
        int c0;
        int at;
        int k;
        logic [9:0] frame;
        tick();
        c0    = cyc;
        at    = c0 + STOP_OFS;
        frame = {stop_ok, b, 1'b0};
        if (abort_bit < 0) begin
            ev_q.push_back('{at, b, stop_ok});
        end
        for (int t = 0; t < 10 * int'(CPB); t++) begin
            k  = t / int'(CPB);
            rx = frame[k];
            if (ready_pulse) begin
                out_ready = (cyc == at);
            end
            if (abort_bit >= 0 && k == abort_bit + 1 && (t % int'(CPB)) == int'(CPB) / 2) begin
                reset = 1'b0;
                rx    = 1'b1;
                idle(2);
                reset = 1'b1;
                return;
            end
            tick();
        end
        if (!stop_ok) begin
            idle(extra_low);
        end
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        bit         bad;
        reset     = 1'b0;
        rx        = 1'b1;
        out_ready = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(5);

        // Single byte with consumer ready
        out_ready = 1'b1;
        send_frame(8'hA5);
        idle(10);

        // Short low glitch is rejected
        tick();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        check("busy_in_glitch", 32'(busy), 1);
        idle(20);
        check("busy_after_glitch", 32'(busy), 0);
        send_frame(8'h3C);
        idle(5);

        // Framing error with held-low line, then recovery
        send_frame(8'h81, 1'b0, 40);
        idle(10);
        check("busy_after_break", 32'(busy), 0);
        send_frame(8'h7E);
        idle(5);

        // Fill past capacity with consumer stalled, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i));
        end
        idle(5);
        out_ready = 1'b1;
        idle(10);

        // Full FIFO, pop exactly in the push cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(8'h10 + i));
        end
        send_frame(8'h14, 1'b1, 0, 1'b1);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        idle(10);

        // Reset in the middle of a frame
        send_frame(8'hFF, 1'b1, 0, 1'b0, 4);
        idle(5);
        check("busy_after_abort", 32'(busy), 0);
        send_frame(8'h55);
        idle(5);

        // Random frames, random stop errors and random consumer stalls
        rnd_ready = 1'b1;
        repeat (40) begin
            rb  = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(rb, !bad, int'($urandom_range(0, 20)));
            idle(int'($urandom_range(2, 20)));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(50);

        check("model_drained", model_q.size(), 0);
        check("events_left", ev_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Standalone UART receiver: the FPGA-side end of the host-to-board serial link. It deserialises 8N1 frames from the board UART RX pin into bytes.
- Buffers received bytes in a small FIFO and presents them on a ready/valid stream to the core or a loader.
- Sits between the board-level pin and any consumer inside the sysclk domain.
- Flags framing errors and FIFO overflow.

Parameters:
- CLKS_PER_BIT, 434, sysclk cycles per bit (50 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 4, byte entries; power of 2, ≥ 2.

Ports:
- clock  in  1  system clock (sysclk domain).
- reset  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- out_valid  out  1  FIFO head byte available.
- out_ready  in  1  consumer accepts head byte.
- out_bits  out  8  FIFO head byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  one-cycle pulse: byte dropped because FIFO full.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
Reset (reset==0 at a clock edge):
- FSM to IDLE, synchroniser flops to 1, FIFO emptied.
- out_valid=0, out_bits=0, frame_err=0, overflow=0, busy=0.
- Reset mid-frame abandons the partial byte; no error pulse.

Input synchroniser:
- 2-flop chain on rx; FSM uses only rx_s, the second flop.
- Falling edge on rx reaches the FSM after 2 cycles.

Counters:
- cnt is ceil(log2(CLKS_PER_BIT)) bits, bit_idx is 3 bits.
- Both clear on every state entry.

FSM states:
- IDLE: rx_s==0 → START.
- START: count to CLKS_PER_BIT/2−1 (integer division), then sample rx_s.
  - Sample 1 → IDLE (glitch rejected, nothing reported).
  - Sample 0 → DATA.
- DATA: count to CLKS_PER_BIT−1, then sample rx_s into shift[bit_idx], LSB first.
  - After bit_idx==7 is sampled → STOP.
- STOP: count to CLKS_PER_BIT−1, then sample rx_s.
  - Sample 1 → push byte into FIFO, go to IDLE.
  - Sample 0 → frame_err pulse, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then → IDLE. A held-low line (break) yields exactly one frame_err.

FIFO:
- Push happens in the cycle the stop sample is taken; out_valid rises on the next cycle.
- out_bits is driven from the head register and is stable while out_valid && !out_ready.
- Pop occurs when out_valid && out_ready.
- Push when full with no pop in the same cycle: byte dropped, overflow pulses for 1 cycle, FIFO contents unchanged.
- Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
- Push and pop in the same cycle while empty: impossible (out_valid=0 that cycle); the push simply lands.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits; full when count==FIFO_DEPTH.
- out_ready while empty has no effect.

Other rules:
- frame_err and overflow never assert in the same cycle; each is a single push or stop event.
- busy=1 in START, DATA, STOP and WAIT_IDLE.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4 unless stated):
1. Reset held low 3 cycles, rx=1 → all outputs 0. Then send 0xA5, 16 cycles/bit, out_ready=1 → out_valid pulses 1 cycle with out_bits=0xA5; frame_err=0.
2. rx low for 5 cycles, then high → no push, busy returns to 0, no frame_err. Then send 0x3C → 0x3C received.
3. Send 0x81 with stop bit driven 0, held low 40 cycles, then high → exactly one frame_err pulse, no out_valid. Next byte 0x7E received correctly.
4. out_ready=0, send 0x01..0x05 → out_valid=1 with head 0x01, and overflow pulses once, after the 5th stop bit. Then out_ready=1 → pops 0x01,0x02,0x03,0x04, then out_valid=0.
5. FIFO full (0x10..0x13), out_ready asserted exactly in the cycle 0x14 is pushed → no overflow. Pop sequence is 0x11,0x12,0x13,0x14.
6. reset driven low during DATA bit 4 of 0xFF, then released with rx=1 → no push, no error. Next frame 0x55 received as 0x55.
